// File: rtl/soft_rst_gen.sv
// rtl/soft_rst_gen.sv - key-protected soft reset pulse generator for IO_CRM (option: SRST_TWO_KEY_EN)
// Without SRST_TWO_KEY_EN a single KEY_B write triggers the pulse and ARMED is unreachable.
module soft_rst_gen #(
  parameter logic [31:0] KEY_A     = 32'hA5A5_5A5A,
  parameter logic [31:0] KEY_B     = 32'h5A5A_A5A5,
  parameter logic [15:0] PULSE_W   = 16'd16,
  parameter logic [15:0] UNLOCK_TO = 16'd1000,
  parameter logic [15:0] HOLDOFF   = 16'd256
) (
  input  logic        clk_125m,
  input  logic        rst_125m,
  input  logic        reg_wr_en,
  input  logic [31:0] reg_wr_data,
  output logic        soft_rst,
  output logic        srst_busy,
  output logic [1:0]  srst_state,
  output logic        key_err,
  output logic [7:0]  key_err_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_PULSE = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic        soft_rst_q, soft_rst_d;
  logic        busy_q, busy_d;
  logic        key_err_q, key_err_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

`ifndef SRST_TWO_KEY_EN
  logic unused_cfg;
  assign unused_cfg = ^{KEY_A, UNLOCK_TO};
`endif

  always_comb begin
    state_d   = state_q;
    key_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (reg_wr_en) begin
`ifdef SRST_TWO_KEY_EN
          if (reg_wr_data == KEY_A) state_d = S_ARMED;
`else
          if (reg_wr_data == KEY_B) state_d = S_PULSE;
`endif
          else key_err_d = 1'b1;
        end
      end
`ifdef SRST_TWO_KEY_EN
      S_ARMED: begin
        // A write in the timeout cycle still decides the outcome.
        if (reg_wr_en) begin
          if (reg_wr_data == KEY_B) begin
            state_d = S_PULSE;
          end else begin
            state_d   = S_IDLE;
            key_err_d = 1'b1;
          end
        end else if (timer_q == UNLOCK_TO - 16'd1) begin
          state_d = S_IDLE;
        end
      end
`endif
      S_PULSE: if (timer_q == PULSE_W - 16'd1) state_d = S_HOLD;
      S_HOLD:  if (timer_q == HOLDOFF - 16'd1) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    timer_d    = (state_d != state_q || state_d == S_IDLE) ? 16'd0 : timer_q + 16'd1;
    // Outputs follow the next state so they line up with the state register.
    soft_rst_d = (state_d != S_PULSE);
    busy_d     = (state_d != S_IDLE);
    err_cnt_d  = (key_err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  always_ff @(posedge clk_125m or posedge rst_125m) begin
    if (rst_125m) begin
      state_q    <= S_IDLE;
      timer_q    <= 16'd0;
      soft_rst_q <= 1'b1;
      busy_q     <= 1'b0;
      key_err_q  <= 1'b0;
      err_cnt_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      soft_rst_q <= soft_rst_d;
      busy_q     <= busy_d;
      key_err_q  <= key_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign soft_rst    = soft_rst_q;
  assign srst_busy   = busy_q;
  assign srst_state  = state_q;
  assign key_err     = key_err_q;
  assign key_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_soft_rst_gen.sv
// tb/tb_soft_rst_gen.sv - self-checking bench for soft_rst_gen (follows SRST_TWO_KEY_EN)
module tb_soft_rst_gen;
  localparam logic [31:0] KA = 32'hA5A5_5A5A;
  localparam logic [31:0] KB = 32'h5A5A_A5A5;
  localparam int PW  = 16;
  localparam int UTO = 1000;
  localparam int HO  = 256;

  logic        clk_125m = 1'b0;
  logic        rst_125m = 1'b0;
  logic        reg_wr_en = 1'b0;
  logic [31:0] reg_wr_data = 32'd0;
  logic        soft_rst, srst_busy, key_err;
  logic [1:0]  srst_state;
  logic [7:0]  key_err_cnt;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  soft_rst_gen dut (
    .clk_125m   (clk_125m),
    .rst_125m   (rst_125m),
    .reg_wr_en  (reg_wr_en),
    .reg_wr_data(reg_wr_data),
    .soft_rst   (soft_rst),
    .srst_busy  (srst_busy),
    .srst_state (srst_state),
    .key_err    (key_err),
    .key_err_cnt(key_err_cnt)
  );

  always #4 clk_125m = ~clk_125m;

  // Model: state plus cycles remaining in it, counted down from the state's dwell length.
  typedef struct {
    int st;
    int left;
    int cnt;
    bit err;
  } mdl_t;

  mdl_t m = '{0, 0, 0, 1'b0};

  function automatic mdl_t step(input mdl_t c, input logic en, input logic [31:0] d);
    mdl_t n;
    n = c;
    n.err = 1'b0;
    case (c.st)
      0: if (en) begin
`ifdef SRST_TWO_KEY_EN
        if (d == KA) begin n.st = 1; n.left = UTO; end
`else
        if (d == KB) begin n.st = 2; n.left = PW; end
`endif
        else n.err = 1'b1;
      end
      1: if (en) begin
        if (d == KB) begin n.st = 2; n.left = PW; end
        else begin n.st = 0; n.err = 1'b1; end
      end else begin
        n.left = c.left - 1;
        if (n.left == 0) n.st = 0;
      end
      2: begin
        n.left = c.left - 1;
        if (n.left == 0) begin n.st = 3; n.left = HO; end
      end
      default: begin
        n.left = c.left - 1;
        if (n.left == 0) n.st = 0;
      end
    endcase
    if (n.err && n.cnt < 255) n.cnt = n.cnt + 1;
    return n;
  endfunction

  always @(posedge clk_125m or posedge rst_125m) begin
    if (rst_125m) m <= '{0, 0, 0, 1'b0};
    else          m <= step(m, reg_wr_en, reg_wr_data);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_125m) begin
    if (chk_en) begin
      check("soft_rst", soft_rst, m.st != 2);
      check("busy", srst_busy, m.st != 0);
      check("state", srst_state, m.st);
      check("key_err", key_err, m.err);
      check("err_cnt", key_err_cnt, m.cnt);
    end
  end

  task automatic wr(input logic [31:0] d);
    @(negedge clk_125m);
    reg_wr_en = 1'b1;
    reg_wr_data = d;
    @(negedge clk_125m);
    reg_wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_125m);
  endtask

  task automatic fire();
`ifdef SRST_TWO_KEY_EN
    wr(KA);
    idle(9);
`endif
    wr(KB);
  endtask

  task automatic pulse_len(input bit inject, output int lo);
    lo = 0;
    for (int i = 0; i < 40; i++) begin
      if (!soft_rst) lo++;
      reg_wr_en = inject && (i == 5);
      reg_wr_data = KB;
      @(negedge clk_125m);
    end
    reg_wr_en = 1'b0;
  endtask

  task automatic wait_idle(input bit inject, input int budget, output int n);
    n = 0;
    for (int i = 0; i < budget; i++) begin
      if (srst_state == 2'd0) break;
      reg_wr_en = inject && (i == 10);
      reg_wr_data = KB;
      n++;
      @(negedge clk_125m);
    end
    reg_wr_en = 1'b0;
    check("idle_reached", srst_state, 2'd0);
  endtask

  initial begin
    int lo, n;
    #2 rst_125m = 1'b1;
    #1;
    check("rst_soft_rst", soft_rst, 1'b1);
    check("rst_busy", srst_busy, 1'b0);
    check("rst_state", srst_state, 2'd0);
    check("rst_key_err", key_err, 1'b0);
    check("rst_cnt", key_err_cnt, 8'd0);
    idle(2);
    rst_125m = 1'b0;
    chk_en = 1'b1;
    idle(2);

    fire();
    check("t1_first_low", soft_rst, 1'b0);
    pulse_len(1'b0, lo);
    check("t1_width", lo, PW);
    wait_idle(1'b0, 400, n);
    check("t1_busy_len", n, PW + HO - 40);

`ifdef SRST_TWO_KEY_EN
    wr(KA);
    check("t2_armed", srst_state, 2'd1);
    wait_idle(1'b0, 1200, n);
    check("t2_timeout", n, UTO);
    check("t2_cnt", key_err_cnt, 8'd0);
`endif

    wr(32'h1234_5678);
    check("t3_err", key_err, 1'b1);
    check("t3_cnt1", key_err_cnt, 8'd1);
    idle(1);
    check("t3_err_drop", key_err, 1'b0);
`ifdef SRST_TWO_KEY_EN
    wr(KA);
    wr(32'h0000_0000);
`else
    wr(KA);
`endif
    check("t3_state", srst_state, 2'd0);
    check("t3_cnt2", key_err_cnt, 8'd2);
    idle(3);

    fire();
    pulse_len(1'b1, lo);
    check("t4_width", lo, PW);
    wait_idle(1'b1, 400, n);
    check("t4_busy_len", n, PW + HO - 40);
    check("t4_cnt", key_err_cnt, 8'd2);

    fire();
    @(posedge clk_125m);
    @(posedge clk_125m);
    #2 rst_125m = 1'b1;
    #1;
    check("t5_soft_rst", soft_rst, 1'b1);
    check("t5_state", srst_state, 2'd0);
    check("t5_busy", srst_busy, 1'b0);
    check("t5_cnt", key_err_cnt, 8'd0);
    idle(2);
    rst_125m = 1'b0;
    idle(2);
    fire();
    pulse_len(1'b0, lo);
    check("t5_width", lo, PW);
    wait_idle(1'b0, 400, n);

    for (int i = 0; i < 300; i++) wr(i);
    check("t3_sat", key_err_cnt, 8'hFF);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
